// File: rtl/fix2flt_unit.sv
// Fixed-to-float stage: reads signed Q8.8 from data memory, writes IEEE-754 half back.
// Optional macro FIX2FLT_ROUND_EN enables round-to-nearest-even in PACK (default truncates).
module fix2flt_unit #(
  parameter int SRC_ADDR = 0,
  parameter int DST_ADDR = 4,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
  output logic          mem_we
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, ABS, NORM, PACK, WR_LO, WR_HI, DONE
  } state_t;

  // Truncation to AW bits gives the modulo-2**AW address wrap.
  localparam logic [AW-1:0] SRC_LO = AW'(SRC_ADDR);
  localparam logic [AW-1:0] SRC_HI = AW'(SRC_ADDR + 1);
  localparam logic [AW-1:0] DST_LO = AW'(DST_ADDR);
  localparam logic [AW-1:0] DST_HI = AW'(DST_ADDR + 1);

  state_t             state_q, state_d;
  logic signed [15:0] x_q, x_d;
  logic               sign_q, sign_d;
  logic [15:0]        mag_q, mag_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        result_q, result_d;
  logic               done_q, done_d;

  // mag is normalised (bit 15 set), so the exponent is 22 - shift count.
  function automatic logic [15:0] pack_half(input logic s, input logic [3:0] c,
                                            input logic [15:0] m);
    logic [4:0]  e;
    logic [14:0] em;
`ifdef FIX2FLT_ROUND_EN
    logic        rnd;
`endif
    e  = 5'd22 - {1'b0, c};
    em = {e, m[14:5]};
`ifdef FIX2FLT_ROUND_EN
    // Mantissa carry-out ripples into the exponent field.
    rnd = m[4] & ((|m[3:0]) | m[5]);
    em  = em + {14'd0, rnd};
`endif
    return {s, em};
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RD_LO;
      RD_LO: begin
        mem_addr     = SRC_LO;
        x_d[7:0]     = mem_rdata;
        state_d      = RD_HI;
      end
      RD_HI: begin
        mem_addr     = SRC_HI;
        x_d[15:8]    = mem_rdata;
        state_d      = ABS;
      end
      ABS: begin
        sign_d = x_q[15];
        mag_d  = x_q[15] ? (~x_q + 16'd1) : x_q;
        cnt_d  = 4'd0;
        if (x_q == 16'sd0) begin
          result_d = 16'h0000;
          state_d  = WR_LO;
        end else begin
          state_d  = NORM;
        end
      end
      NORM: begin
        if (mag_q[15]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      PACK: begin
        result_d = pack_half(sign_q, cnt_q, mag_q);
        state_d  = WR_LO;
      end
      WR_LO: begin
        mem_addr  = DST_LO;
        mem_wdata = result_q[7:0];
        mem_we    = 1'b1;
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_addr  = DST_HI;
        mem_wdata = result_q[15:8];
        mem_we    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (start) state_d = RD_LO;
        else       done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_fix2flt_unit.sv
// Bench for fix2flt_unit: directed Q8.8 vectors, expected halves queued at start,
// checked by a monitor on each rising done against memory contents and latency.
module tb_fix2flt_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  logic [7:0] mem [0:255];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;
  exp_t q[$];

  fix2flt_unit #(.SRC_ADDR(0), .DST_ADDR(4), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Monitor: on every rising done, pop the oldest expectation and compare.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        logic [15:0] got;
        e   = q.pop_front();
        got = {mem[5], mem[4]};
        checks++;
        if (got !== e.res) begin
          failures++;
          $display("FAIL %s result got=%h want=%h", e.name, got, e.res);
        end
        checks++;
        if (cyc - e.t0 != e.lat) begin
          failures++;
          $display("FAIL %s latency got=%0d want=%0d", e.name, cyc - e.t0, e.lat);
        end
      end
    end
    done_prev <= done;
  end

  task automatic check1(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic load(input logic [15:0] x);
    mem[0] = x[7:0];
    mem[1] = x[15:8];
    mem[4] = 8'hEE;
    mem[5] = 8'hEE;
  endtask

  // Issue one conversion; optionally pulse start again while the unit is busy.
  task automatic run(input string nm, input logic [15:0] x, input logic [15:0] want,
                     input int lat, input bit mid_start);
    exp_t e;
    int   n;
    @(negedge clk);
    load(x);
    start = 1'b1;
    e.res = want; e.lat = lat; e.t0 = cyc + 1; e.name = nm;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (mid_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for done", nm);
      q.delete();
    end
    repeat (2) @(negedge clk);
    check1({nm, "_done_held"}, {15'd0, done}, 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_done",  {15'd0, done},   16'd0);
    check1("rst_we",    {15'd0, mem_we}, 16'd0);
    check1("rst_addr",  {8'd0, mem_addr},  16'd0);
    check1("rst_wdata", {8'd0, mem_wdata}, 16'd0);
    reset = 1'b0;

    run("one",      16'h0100, 16'h3C00, 15, 1'b0);
    run("neg_one",  16'hFF00, 16'hBC00, 15, 1'b0);
    run("zero",     16'h0000, 16'h0000,  6, 1'b0);
    run("neg128",   16'h8000, 16'hD800,  8, 1'b0);
    run("lsb",      16'h0001, 16'h1C00, 23, 1'b0);
`ifdef FIX2FLT_ROUND_EN
    run("max_pos",  16'h7FFF, 16'h5800,  9, 1'b0);
`else
    run("max_pos",  16'h7FFF, 16'h57FF,  9, 1'b0);
`endif
    run("mid_start", 16'h0100, 16'h3C00, 15, 1'b1);

    // Abort a long conversion while normalising, then restart cleanly.
    @(negedge clk);
    load(16'h0001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check1("midrst_done", {15'd0, done},   16'd0);
    check1("midrst_we",   {15'd0, mem_we}, 16'd0);
    repeat (25) @(negedge clk);
    check1("midrst_no_write", {mem[5], mem[4]}, 16'hEEEE);
    run("after_rst", 16'h0200, 16'h4000, 14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
